mpt_mem_responder: RTL
======================

Name: mpt_mem_responder

Overview:
- Memory-side responder for the MPT walker's req/gnt/rvalid read protocol; it is the slave end that the walker's WAIT_FOR_GRANT and WAIT_FOR_RVALID states talk to.
- Holds MPTL2/MPTL1 table words in an internal array that is loaded through a config write port.
- Grant and response latencies are configurable. Responses return in order with an error flag for bad addresses.
- Used as the table backing store in walker subsystem benches and in small FPGA builds.

Parameters:
- DEPTH, 1024, number of XLEN-bit table words (power of two).
- BASE_ADDR, 34'h0, physical byte address of word 0 (PLEN bits, DEPTH*4-aligned).
- GNT_LAT, 1, cycles from req_i first sampled high to gnt_o (0..7; 0 = combinational same-cycle grant).
- RSP_LAT, 1, cycles from grant cycle to rvalid_o (1..7).
- MAX_OUTST, 2, granted-but-unanswered requests allowed (1..4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  walker read request, held until gnt_o
- addr_i  in  PLEN  byte address of requested entry
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid, single-cycle pulse
- rdata_o  out  XLEN  table word; zero when err_o is high
- err_o  out  1  access fault, qualified by rvalid_o
- cfg_we_i  in  1  table word write strobe
- cfg_idx_i  in  $clog2(DEPTH)  word index to write
- cfg_wdata_i  in  XLEN  word to write
- outst_o  out  $clog2(MAX_OUTST+1)  current outstanding count

Behaviour:
- Reset (async, rst_ni=0): gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, outst_o=0, grant FSM in G_IDLE, response queue empty. Table contents are not reset.
- Grant FSM states:
  - G_IDLE: if req_i=1 and outst<MAX_OUTST, then with GNT_LAT=0 drive gnt_o=1 combinationally and stay; otherwise load cnt=GNT_LAT-1 and go to G_WAIT.
  - G_WAIT: if req_i drops, return to G_IDLE (request abandoned, nothing queued). If cnt==0 and outst<MAX_OUTST, gnt_o=1 and go to G_IDLE. Otherwise decrement cnt, saturating at 0.
  - G_FULL: entered from G_IDLE or G_WAIT when outst==MAX_OUTST with req_i high. Leave to G_WAIT with cnt=0 once outst<MAX_OUTST, giving a grant the next cycle.
- Occupancy: outst is a registered value with no same-cycle bypass. A response retiring in cycle N frees a slot for a grant in cycle N+1.
- On each grant:
  - off = addr_i - BASE_ADDR.
  - err if addr_i<BASE_ADDR, off>=DEPTH*4, or addr_i[1:0]!=0.
  - Otherwise latch mem[off>>2] as the response data.
  - Push {data, err} into the response FIFO with timer=RSP_LAT-1.
- Response timing: the FIFO head's timer counts down every cycle. rvalid_o pulses for 1 cycle exactly RSP_LAT cycles after its grant cycle. Responses are strictly in order. All entries age in parallel, so constant latency holds for back-to-back grants.
- Config write: on cfg_we_i, mem[cfg_idx_i]<=cfg_wdata_i at the clock edge. A grant in the same cycle to the same index returns the old word (read-before-write).
- Simultaneous grant and retire: outst is unchanged.
- Reset mid-transaction drops all queued responses. The walker must also be in reset.
- gnt_o is never asserted when req_i=0.

Decomposition:
- Add to mpt_pkg:
  - resp_state_e {G_IDLE, G_WAIT, G_FULL}
  - mpt_rsp_t {logic err; logic [XLEN-1:0] data}
  - MPT_WORD_BYTES = XLEN/8
- Sub-module: mpt_rsp_fifo, a MAX_OUTST-deep in-order queue of mpt_rsp_t with per-entry countdown timers. It outputs head_valid when the head timer reaches 0 and exposes its count.

Test Plan:
- Reset release, GNT_LAT=1, RSP_LAT=1: cfg write idx 3 = 32'h0400_0001; req addr 34'h0C → gnt_o at cycle+1, rvalid_o next cycle with rdata_o=32'h0400_0001, err_o=0.
- GNT_LAT=0, RSP_LAT=3, req held for 3 back-to-back requests, MAX_OUTST=2 → gnt_o in cycles 0 and 1, third grant stalls (G_FULL) until cycle 4 (first rvalid in cycle 3), then three rvalids in order.
- Req addr 34'h0E (misaligned) and 34'h1000 (DEPTH=1024, out of range) → rvalid with err_o=1, rdata_o=0.
- req_i dropped after 1 cycle with GNT_LAT=3 → no gnt_o, no rvalid_o, outst_o stays 0.
- Same-cycle cfg write idx 5 = 32'hFFFF and grant to 34'h14 (old value 32'h1234) → rdata_o=32'h1234; next read returns 32'hFFFF.
- rst_ni asserted with 2 outstanding → rvalid_o=0 and outst_o=0 immediately; no stale response after release.

Source files
------------

// File: rtl/mpt_pkg.sv
// Shared types and constants for the MPT walker and its memory-side responder.
package mpt_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned PLEN           = 34;
  localparam int unsigned MPT_WORD_BYTES = XLEN / 8;

  typedef enum logic [1:0] {
    G_IDLE,
    G_WAIT,
    G_FULL
  } resp_state_e;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } mpt_rsp_t;

endpackage

// File: rtl/mpt_rsp_fifo.sv
// In-order response queue; every entry carries its own countdown so queued
// responses age in parallel and each one leaves exactly LAT cycles after push.
module mpt_rsp_fifo
  import mpt_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned LAT   = 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  mpt_rsp_t      push_data,
  input  logic          pop,
  output logic          head_valid,
  output mpt_rsp_t      head_data,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [2:0]    timer [DEPTH];
  mpt_rsp_t      entry [DEPTH];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) timer[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (timer[i] != '0) timer[i] <= timer[i] - 3'd1;
      end
      // A fresh push overrides the aging of its (free) slot.
      if (push) begin
        timer[wr_ptr] <= 3'(LAT - 1);
        wr_ptr        <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) entry[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0) && (timer[rd_ptr] == '0);
  assign head_data  = entry[rd_ptr];

endmodule

// File: rtl/mpt_mem_responder.sv
// Memory-side slave for the MPT walker req/gnt/rvalid read protocol, backed by
// a config-loaded table with configurable grant and response latency.
module mpt_mem_responder
  import mpt_pkg::*;
#(
  parameter  int unsigned     DEPTH     = 1024,
  parameter  logic [PLEN-1:0] BASE_ADDR = 34'h0,
  parameter  int unsigned     GNT_LAT   = 1,
  parameter  int unsigned     RSP_LAT   = 1,
  parameter  int unsigned     MAX_OUTST = 2,
  localparam int unsigned     IW        = $clog2(DEPTH),
  localparam int unsigned     OW        = $clog2(MAX_OUTST + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [PLEN-1:0] addr_i,
  output logic            gnt_o,
  output logic            rvalid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  input  logic            cfg_we_i,
  input  logic [IW-1:0]   cfg_idx_i,
  input  logic [XLEN-1:0] cfg_wdata_i,
  output logic [OW-1:0]   outst_o
);

  localparam int unsigned     AW   = $clog2(MPT_WORD_BYTES);
  localparam logic [PLEN-1:0] SPAN = PLEN'(DEPTH * MPT_WORD_BYTES);

  resp_state_e     state, state_next;
  logic [2:0]      cnt, cnt_next;
  logic            gnt;
  logic            full;
  logic            head_valid;
  mpt_rsp_t        head;
  mpt_rsp_t        rsp_in;
  logic [OW-1:0]   outst;
  logic [PLEN-1:0] off;
  logic            addr_err;
  logic [IW-1:0]   word_idx;
  logic [XLEN-1:0] mem [DEPTH];

  assign full = (outst >= OW'(MAX_OUTST));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= G_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gnt        = 1'b0;
    unique case (state)
      G_IDLE: begin
        if (req_i) begin
          if (full) begin
            state_next = G_FULL;
          end else if (GNT_LAT == 0) begin
            gnt = 1'b1;
          end else begin
            cnt_next   = 3'(GNT_LAT - 1);
            state_next = G_WAIT;
          end
        end
      end
      G_WAIT: begin
        if (!req_i) begin
          state_next = G_IDLE;
        end else if (cnt == '0 && !full) begin
          gnt        = 1'b1;
          state_next = G_IDLE;
        end else if (cnt != '0) begin
          cnt_next = cnt - 3'd1;
        end else if (!head_valid) begin
          state_next = G_FULL;
        end
      end
      G_FULL: begin
        // Leaving on the retire cycle itself lets the grant land in the cycle
        // the registered occupancy first shows a free slot.
        if (!req_i) begin
          state_next = G_IDLE;
        end else if (!full || head_valid) begin
          cnt_next   = '0;
          state_next = G_WAIT;
        end
      end
      default: state_next = G_IDLE;
    endcase
  end

  assign gnt_o = gnt & rst_ni;

  always_comb begin
    off      = addr_i - BASE_ADDR;
    addr_err = (addr_i < BASE_ADDR) || (off >= SPAN) || (addr_i[AW-1:0] != '0);
    word_idx = off[AW +: IW];
    rsp_in.err  = addr_err;
    rsp_in.data = addr_err ? '0 : mem[word_idx];
  end

  always_ff @(posedge clk_i) begin
    if (cfg_we_i) mem[cfg_idx_i] <= cfg_wdata_i;
  end

  mpt_rsp_fifo #(
    .DEPTH(MAX_OUTST),
    .LAT  (RSP_LAT)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (gnt_o),
    .push_data (rsp_in),
    .pop       (head_valid),
    .head_valid(head_valid),
    .head_data (head),
    .count     (outst)
  );

  assign rvalid_o = head_valid;
  assign err_o    = head_valid & head.err;
  assign rdata_o  = (head_valid && !head.err) ? head.data : '0;
  assign outst_o  = outst;

endmodule
